// File: rtl/msrh_l2_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msrh_l2_req_arbiter                                           |
// | Purpose  : Shares one L2 request/response port between REQ_NUM           |
// |            requesters. The winning request is registered toward L2      |
// |            with the requester ID prepended to its tag. Responses are    |
// |            routed back by that ID. Reads in flight are capped at        |
// |            MAX_OUTS per requester.                                      |
// | Ports    : i_clk/i_reset      clock, synchronous active-high reset       |
// |            i_req_*            per-requester request channel (packed)     |
// |            o_req_ready        one-hot (or zero) grant                    |
// |            o_resp_*           routed response, tag with ID stripped      |
// |            i_resp_ready       per-requester response ready               |
// |            o_l2_req_*         registered request toward L2               |
// |            i_l2_req_ready     L2 accepts the registered request          |
// |            i_l2_resp_*        response from L2                           |
// |            o_l2_resp_ready    response ready toward L2                   |
// |            o_err_bad_id       pulse: response carried an unknown ID      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module msrh_l2_req_arbiter #(
   parameter int REQ_NUM  = 2,
   parameter int TAG_W    = 8,
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 56,
   parameter int MAX_OUTS = 4,
   localparam int ID_W    = $clog2(REQ_NUM),
   localparam int CMD_W   = 5,
   localparam int BE_W    = DATA_W / 8
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic [REQ_NUM-1:0]                 i_req_valid,
   input  logic [REQ_NUM-1:0][CMD_W-1:0]      i_req_cmd,
   input  logic [REQ_NUM-1:0][ADDR_W-1:0]     i_req_addr,
   input  logic [REQ_NUM-1:0][TAG_W-1:0]      i_req_tag,
   input  logic [REQ_NUM-1:0][DATA_W-1:0]     i_req_data,
   input  logic [REQ_NUM-1:0][BE_W-1:0]       i_req_byte_en,
   output logic [REQ_NUM-1:0]                 o_req_ready,
   output logic [REQ_NUM-1:0]                 o_resp_valid,
   output logic [TAG_W-1:0]                   o_resp_tag,
   output logic [DATA_W-1:0]                  o_resp_data,
   input  logic [REQ_NUM-1:0]                 i_resp_ready,
   output logic                               o_l2_req_valid,
   output logic [CMD_W-1:0]                   o_l2_req_cmd,
   output logic [ADDR_W-1:0]                  o_l2_req_addr,
   output logic [ID_W+TAG_W-1:0]              o_l2_req_tag,
   output logic [DATA_W-1:0]                  o_l2_req_data,
   output logic [BE_W-1:0]                    o_l2_req_byte_en,
   input  logic                               i_l2_req_ready,
   input  logic                               i_l2_resp_valid,
   input  logic [ID_W+TAG_W-1:0]              i_l2_resp_tag,
   input  logic [DATA_W-1:0]                  i_l2_resp_data,
   output logic                               o_l2_resp_ready,
   output logic                               o_err_bad_id
);

   localparam int CNT_W = $clog2(MAX_OUTS + 1);

   // mem_cmd_t encoding: M_XRD = 0, M_XWR = 1. Only reads are counted.
   localparam logic [CMD_W-1:0] c_m_xrd = 5'b00000;

   logic                  l2_valid_q;
   logic [CMD_W-1:0]      l2_cmd_q;
   logic [ADDR_W-1:0]     l2_addr_q;
   logic [ID_W+TAG_W-1:0] l2_tag_q;
   logic [DATA_W-1:0]     l2_data_q;
   logic [BE_W-1:0]       l2_be_q;
   logic [ID_W-1:0]       ptr_q;
   logic [ID_W-1:0]       ptr_d;
   logic [CNT_W-1:0]      outs_q [REQ_NUM];
   logic [CNT_W-1:0]      outs_d [REQ_NUM];

   logic                  w_ld;
   logic [REQ_NUM-1:0]    w_elig;
   logic [REQ_NUM-1:0]    w_grant;
   logic [ID_W-1:0]       w_gid;
   logic                  w_found;
   logic                  w_grant_en;
   logic [ID_W:0]         w_scan;
   logic [ID_W-1:0]       w_resp_id;
   logic                  w_id_ok;
   logic                  w_resp_hs;

   // The output register may take a new beat when empty or being drained.
   assign w_ld = !l2_valid_q || i_l2_req_ready;

   // Round-robin scan starting at ptr_q; w_scan carries one extra bit so
   // the wrap past REQ_NUM-1 works for non-power-of-two requester counts.
   always_comb begin
      w_grant = '0;
      w_gid   = '0;
      w_found = 1'b0;
      w_scan  = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         w_scan = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (w_scan >= (ID_W+1)'(REQ_NUM)) begin
            w_scan = w_scan - (ID_W+1)'(REQ_NUM);
         end
         if (!w_found && w_elig[w_scan[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_gid   = w_scan[ID_W-1:0];
         end
      end
      w_grant_en = w_found && w_ld && !i_reset;
      if (w_grant_en) begin
         w_grant[w_gid] = 1'b1;
      end
   end

   assign o_req_ready = w_grant;
   assign ptr_d       = (w_gid == ID_W'(REQ_NUM - 1)) ? '0 : w_gid + ID_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         l2_valid_q <= 1'b0;
         ptr_q      <= '0;
      end else begin
         if (w_ld) begin
            l2_valid_q <= w_grant_en;
         end
         if (w_grant_en) begin
            ptr_q <= ptr_d;
         end
      end
   end

   // Payload needs no reset: it is only meaningful while l2_valid_q is set.
   always_ff @(posedge i_clk) begin
      if (w_grant_en) begin
         l2_cmd_q  <= i_req_cmd[w_gid];
         l2_addr_q <= i_req_addr[w_gid];
         l2_tag_q  <= {w_gid, i_req_tag[w_gid]};
         l2_data_q <= i_req_data[w_gid];
         l2_be_q   <= i_req_byte_en[w_gid];
      end
   end

   assign o_l2_req_valid   = l2_valid_q;
   assign o_l2_req_cmd     = l2_cmd_q;
   assign o_l2_req_addr    = l2_addr_q;
   assign o_l2_req_tag     = l2_tag_q;
   assign o_l2_req_data    = l2_data_q;
   assign o_l2_req_byte_en = l2_be_q;

   // Response path: purely combinational, routed by the ID in the tag MSBs.
   assign w_resp_id = i_l2_resp_tag[TAG_W +: ID_W];
   assign w_id_ok   = ({1'b0, w_resp_id} < (ID_W+1)'(REQ_NUM));

   // Unknown IDs are always accepted so a bad response cannot stall L2.
   always_comb begin
      o_l2_resp_ready = 1'b1;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (w_resp_id == ID_W'(k)) begin
            o_l2_resp_ready = i_resp_ready[k];
         end
      end
   end

   assign w_resp_hs    = i_l2_resp_valid && w_id_ok && o_l2_resp_ready;
   assign o_resp_tag   = i_l2_resp_tag[TAG_W-1:0];
   assign o_resp_data  = i_l2_resp_data;
   assign o_err_bad_id = i_l2_resp_valid && !w_id_ok && !i_reset;

   for (genvar k = 0; k < REQ_NUM; k++) begin : g_req
      logic w_inc;
      logic w_dec;

      assign w_elig[k] = i_req_valid[k] &&
                         ((i_req_cmd[k] != c_m_xrd) || (outs_q[k] < CNT_W'(MAX_OUTS)));
      assign o_resp_valid[k] = i_l2_resp_valid && (w_resp_id == ID_W'(k));

      assign w_inc = w_grant[k] && (i_req_cmd[k] == c_m_xrd);
      assign w_dec = w_resp_hs && (w_resp_id == ID_W'(k));

      // Decrement at zero is ignored: a stale response may arrive after reset.
      always_comb begin
         outs_d[k] = outs_q[k];
         if (w_inc && !w_dec) begin
            outs_d[k] = outs_q[k] + CNT_W'(1);
         end else if (w_dec && !w_inc && (outs_q[k] != '0)) begin
            outs_d[k] = outs_q[k] - CNT_W'(1);
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            outs_q[k] <= '0;
         end else begin
            outs_q[k] <= outs_d[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_msrh_l2_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_msrh_l2_req_arbiter                                        |
// | Purpose  : Self-checking bench for msrh_l2_req_arbiter with three        |
// |            requesters: directed scenarios followed by random traffic,   |
// |            all compared against a behavioural model.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_msrh_l2_req_arbiter;

   localparam int REQ_NUM  = 3;
   localparam int TAG_W    = 8;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int MAX_OUTS = 4;
   localparam int ID_W     = 2;
   localparam int BE_W     = DATA_W / 8;
   localparam logic [4:0] XRD = 5'd0;
   localparam logic [4:0] XWR = 5'd1;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [REQ_NUM-1:0]             req_valid;
   logic [REQ_NUM-1:0][4:0]        req_cmd;
   logic [REQ_NUM-1:0][ADDR_W-1:0] req_addr;
   logic [REQ_NUM-1:0][TAG_W-1:0]  req_tag;
   logic [REQ_NUM-1:0][DATA_W-1:0] req_data;
   logic [REQ_NUM-1:0][BE_W-1:0]   req_be;
   logic [REQ_NUM-1:0]             req_ready;
   logic [REQ_NUM-1:0]             resp_valid;
   logic [TAG_W-1:0]               resp_tag;
   logic [DATA_W-1:0]              resp_data;
   logic [REQ_NUM-1:0]             resp_ready;
   logic                           l2_req_valid;
   logic [4:0]                     l2_req_cmd;
   logic [ADDR_W-1:0]              l2_req_addr;
   logic [ID_W+TAG_W-1:0]          l2_req_tag;
   logic [DATA_W-1:0]              l2_req_data;
   logic [BE_W-1:0]                l2_req_be;
   logic                           l2_req_ready;
   logic                           l2_resp_valid;
   logic [ID_W+TAG_W-1:0]          l2_resp_tag;
   logic [DATA_W-1:0]              l2_resp_data;
   logic                           l2_resp_ready;
   logic                           err_bad_id;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit                    m_valid;
   logic [4:0]            m_cmd;
   logic [ADDR_W-1:0]     m_addr;
   logic [ID_W+TAG_W-1:0] m_tag;
   logic [DATA_W-1:0]     m_data;
   logic [BE_W-1:0]       m_be;
   int                    m_ptr;
   int                    m_outs [REQ_NUM];
   int                    m_gnt;
   int                    m_hs;
   bit                    m_ld;

   msrh_l2_req_arbiter #(
      .REQ_NUM (REQ_NUM),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .MAX_OUTS(MAX_OUTS)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_req_valid     (req_valid),
      .i_req_cmd       (req_cmd),
      .i_req_addr      (req_addr),
      .i_req_tag       (req_tag),
      .i_req_data      (req_data),
      .i_req_byte_en   (req_be),
      .o_req_ready     (req_ready),
      .o_resp_valid    (resp_valid),
      .o_resp_tag      (resp_tag),
      .o_resp_data     (resp_data),
      .i_resp_ready    (resp_ready),
      .o_l2_req_valid  (l2_req_valid),
      .o_l2_req_cmd    (l2_req_cmd),
      .o_l2_req_addr   (l2_req_addr),
      .o_l2_req_tag    (l2_req_tag),
      .o_l2_req_data   (l2_req_data),
      .o_l2_req_byte_en(l2_req_be),
      .i_l2_req_ready  (l2_req_ready),
      .i_l2_resp_valid (l2_resp_valid),
      .i_l2_resp_tag   (l2_resp_tag),
      .i_l2_resp_data  (l2_resp_data),
      .o_l2_resp_ready (l2_resp_ready),
      .o_err_bad_id    (err_bad_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input bit v, input logic [4:0] cmd,
                          input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag);
      req_valid[k] = v;
      req_cmd[k]   = cmd;
      req_addr[k]  = addr;
      req_tag[k]   = tag;
      req_data[k]  = $urandom;
      req_be[k]    = BE_W'($urandom);
   endtask

   task automatic rand_req(input int k);
      set_req(k, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 80) ? XRD : XWR,
              $urandom, TAG_W'($urandom));
   endtask

   // Settle the combinational outputs, evaluate the arbitration rules on the
   // current inputs and compare every observable output.
   task automatic settle();
      logic [REQ_NUM-1:0] exp_rdy;
      logic [REQ_NUM-1:0] exp_rv;
      int id;
      #1;
      m_ld  = !m_valid || l2_req_ready;
      m_gnt = -1;
      if (m_ld && !rst) begin
         for (int i = 0; i < REQ_NUM; i++) begin
            int k = (m_ptr + i) % REQ_NUM;
            if (m_gnt < 0 && req_valid[k] && (req_cmd[k] != XRD || m_outs[k] < MAX_OUTS))
               m_gnt = k;
         end
      end
      exp_rdy = '0;
      if (m_gnt >= 0) exp_rdy[m_gnt] = 1'b1;
      id = int'(l2_resp_tag[TAG_W +: ID_W]);
      exp_rv = '0;
      if (l2_resp_valid && id < REQ_NUM) exp_rv[id] = 1'b1;
      m_hs = (l2_resp_valid && id < REQ_NUM && resp_ready[id]) ? id : -1;

      chk("req_ready", req_ready, exp_rdy);
      chk("l2_req_valid", l2_req_valid, m_valid);
      if (m_valid) begin
         chk("l2_req_cmd", l2_req_cmd, m_cmd);
         chk("l2_req_addr", l2_req_addr, m_addr);
         chk("l2_req_tag", l2_req_tag, m_tag);
         chk("l2_req_data", l2_req_data, m_data);
         chk("l2_req_be", l2_req_be, m_be);
      end
      chk("resp_valid", resp_valid, exp_rv);
      chk("resp_tag", resp_tag, l2_resp_tag[TAG_W-1:0]);
      chk("resp_data", resp_data, l2_resp_data);
      chk("l2_resp_ready", l2_resp_ready, (id < REQ_NUM) ? resp_ready[id] : 1'b1);
      chk("err_bad_id", err_bad_id, l2_resp_valid && id >= REQ_NUM && !rst);
   endtask

   // Advance the model across the rising edge using the inputs held there.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_ptr   = 0;
         for (int k = 0; k < REQ_NUM; k++) m_outs[k] = 0;
      end else begin
         if (m_ld) begin
            m_valid = (m_gnt >= 0);
            if (m_gnt >= 0) begin
               m_cmd  = req_cmd[m_gnt];
               m_addr = req_addr[m_gnt];
               m_tag  = {ID_W'(m_gnt), req_tag[m_gnt]};
               m_data = req_data[m_gnt];
               m_be   = req_be[m_gnt];
               m_ptr  = (m_gnt + 1) % REQ_NUM;
               if (req_cmd[m_gnt] == XRD) m_outs[m_gnt]++;
            end
         end
         if (m_hs >= 0 && m_outs[m_hs] > 0) m_outs[m_hs]--;
      end
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   initial begin
      logic [REQ_NUM-1:0] t2_seq [4];
      logic [ADDR_W-1:0]  t3_addr;
      t2_seq = '{3'b010, 3'b001, 3'b010, 3'b001};

      // Reset with every requester valid
      rst           = 1'b1;
      l2_req_ready  = 1'b1;
      l2_resp_valid = 1'b0;
      l2_resp_tag   = '0;
      l2_resp_data  = '0;
      resp_ready    = '1;
      m_valid       = 1'b0;
      m_ptr         = 0;
      m_gnt         = -1;
      m_hs          = -1;
      m_ld          = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) begin
         m_outs[k] = 0;
         set_req(k, 1'b1, XWR, $urandom, TAG_W'(k));
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("rst_ready", req_ready, 3'b000);
         chk("rst_l2_valid", l2_req_valid, 1'b0);
         tick();
      end
      rst = 1'b0;
      settle();
      chk("first_grant", req_ready, 3'b001);
      tick();

      // Round robin between req0 and req1 with L2 always ready
      req_valid[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_grant", req_ready, t2_seq[i]);
         tick();
      end

      // Backpressure: held beat must stay put, no grants
      req_valid[0] = 1'b0;
      t3_addr      = 32'hA5A5_0040;
      set_req(1, 1'b1, XWR, t3_addr, 8'h3C);
      l2_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("bp_no_grant", req_ready, 3'b000);
         tick();
      end
      l2_req_ready = 1'b1;
      settle();
      chk("bp_release_grant", req_ready, 3'b010);
      tick();
      req_valid[1] = 1'b0;
      settle();
      chk("bp_new_addr", l2_req_addr, t3_addr);
      chk("bp_new_tag", l2_req_tag, {2'd1, 8'h3C});
      tick();

      // Outstanding read cap on req0
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, XRD, 32'h1000 + 32'(i * 64), TAG_W'(i));
         settle();
         chk("cap_read_grant", req_ready, 3'b001);
         tick();
      end
      set_req(0, 1'b1, XRD, 32'h2000, 8'h44);
      settle();
      chk("cap_blocked", req_ready, 3'b000);
      tick();
      set_req(0, 1'b1, XWR, 32'h3000, 8'h45);
      settle();
      chk("cap_write_ok", req_ready, 3'b001);
      tick();
      set_req(0, 1'b1, XRD, 32'h2000, 8'h44);
      l2_resp_valid = 1'b1;
      l2_resp_tag   = {2'd0, 8'h01};
      l2_resp_data  = 32'hDEAD_0001;
      settle();
      chk("cap_blocked_resp", req_ready, 3'b000);
      tick();
      l2_resp_valid = 1'b0;
      settle();
      chk("cap_freed", req_ready, 3'b001);
      tick();
      req_valid[0] = 1'b0;

      // Response routing with requester 1 not ready
      l2_resp_valid = 1'b1;
      l2_resp_tag   = {2'd1, 8'h05};
      l2_resp_data  = 32'hCAFE_F00D;
      resp_ready    = 3'b101;
      settle();
      chk("route_valid", resp_valid, 3'b010);
      chk("route_tag", resp_tag, 8'h05);
      chk("route_l2_ready", l2_resp_ready, 1'b0);
      tick();

      // Unknown response ID
      l2_resp_tag = {2'd3, 8'h11};
      settle();
      chk("badid_ready", l2_resp_ready, 1'b1);
      chk("badid_valid", resp_valid, 3'b000);
      chk("badid_err", err_bad_id, 1'b1);
      tick();
      l2_resp_valid = 1'b0;
      resp_ready    = '1;
      settle();
      chk("badid_err_clear", err_bad_id, 1'b0);
      tick();

      // Random traffic; requesters hold each request until granted
      for (int k = 0; k < REQ_NUM; k++) rand_req(k);
      for (int c = 0; c < 3000; c++) begin
         rst           = ($urandom_range(0, 199) == 0);
         l2_req_ready  = ($urandom_range(0, 99) < 70);
         l2_resp_valid = ($urandom_range(0, 99) < 30);
         l2_resp_tag   = {($urandom_range(0, 9) == 0) ? 2'd3 : ID_W'($urandom_range(0, 2)),
                          TAG_W'($urandom)};
         l2_resp_data  = $urandom;
         resp_ready    = REQ_NUM'($urandom);
         settle();
         tick();
         for (int k = 0; k < REQ_NUM; k++) begin
            if (m_gnt == k || !req_valid[k]) rand_req(k);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
